msg_len_counter_mc: RTL and testbench
=====================================

// Module: msg_len_counter_mc
// PURPOSE
//  Multi-channel successor to the single-channel message counter. Passively monitors one AXI-Stream
//  slave handshake, keeps an independent beat counter per channel (selected by s_tdest), and on each
//  s_tlast, or on reaching max_len, pushes a {chan, length, split} record into a small result FIFO.
//  Sits beside the stream ingress; never drives tready. Results drain via a valid/ready port.
// PARAMETERS
//  NUM_COUNT_BITS  16  width of per-channel beat counter and reported length
//  NUM_CHANNELS    4   number of channels (>=1); CH_BITS = max(1,$clog2(NUM_CHANNELS))
//  FIFO_DEPTH      4   result FIFO entries; power of two, >=2
// PORTS
//  clk           in   1               clock
//  rst           in   1               synchronous, active-high reset
//  s_tvalid      in   1               monitored stream valid
//  s_tready      in   1               monitored stream ready
//  s_tlast       in   1               monitored end-of-message
//  s_tdest       in   CH_BITS         channel of current beat; >=NUM_CHANNELS ignored
//  clear         in   NUM_CHANNELS    per-channel counter clear
//  max_len       in   NUM_COUNT_BITS  split threshold; 0 = no split (counter saturates)
//  len_valid     out  1               result record available
//  len_ready     in   1               result consumer ready
//  len_data      out  NUM_COUNT_BITS  message length in beats (>=1)
//  len_chan      out  CH_BITS         channel of record
//  len_split     out  1               1 = record closed by max_len, not by tlast
//  chan_busy     out  NUM_CHANNELS    1 = channel has an open message (count>0)
//  drop_cnt      out  8               records lost to full FIFO, saturates at 255
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): all counts, chan_busy, FIFO pointers, drop_cnt = 0; len_valid=0.
//  - Beat = s_tvalid && s_tready && s_tdest < NUM_CHANNELS. Other cycles leave counts unchanged.
//  - Per channel, next = count+1 on beat. Close record when s_tlast, or max_len!=0 && next==max_len.
//    On close: push {chan, next, split=!s_tlast}; count <= 0. Else count <= next.
//  - tlast on the max_len beat: single record, split=0.
//  - max_len==0: count saturates at 2^N-1; the tlast record reports 2^N-1, split=1 if saturated.
//  - max_len changed mid-message: applies from next beat; if count already >= new max_len,
//    the next beat closes the record with split=1 and the actual length.
//  - clear[c]: count[c] <= 0, no record. Clear with same-cycle beat on c: clear first, beat becomes
//    first beat of fresh message (count=1, or length-1 record if tlast).
//  - Record latency: pushed at the edge of the closing beat; len_valid high the following cycle.
//  - FIFO: show-ahead; len_valid = !empty; pop on len_valid && len_ready. Push when full and
//    no same-cycle pop: record dropped, drop_cnt++ (saturating). Full + pop + push: both take place.
//  - Channel counters and FIFO are stall-independent: a backpressured len port never stalls counting.
//  - chan_busy[c] = (count[c] != 0), registered.
// CONFIGURATION
//  MSG_LEN_COUNTER_TIMESTAMP_EN defined: 32-bit free-running cycle counter (0 after reset, wraps)
//   plus output len_ts[31:0] = counter value at the closing-beat edge, stored per FIFO entry.
//  Undefined: no cycle counter, no len_ts port; all other behaviour identical.
// TESTING
//  - rst, then ch1: 5 beats, tlast on 5th, len_ready=1 -> one record {chan=1,len=5,split=0}, chan_busy[1]=0.
//  - Interleave ch0 (3 beats) / ch2 (2 beats), tlast each -> records {2,2,0} then {0,3,0} in closing order.
//  - max_len=4, ch0 sends 10 beats, tlast on 10th -> records 4/split=1, 4/split=1, 2/split=0.
//  - len_ready=0, close 6 single-beat msgs (DEPTH=4) -> 4 records held, drop_cnt=2; drain in order.
//  - clear[3] with beat+tlast on ch3 when count[3]=7 -> record {3,1,0}; s_tdest=NUM_CHANNELS beat -> no change.
//  - rst asserted mid-message with FIFO holding 2 -> len_valid=0, all counts 0 next cycle, drop_cnt=0.

Source files
------------

// File: rtl/msg_len_counter_mc_if.sv
// Stream-monitor and result-port bundle for msg_len_counter_mc.
// Optional len_ts field is present when MSG_LEN_COUNTER_TIMESTAMP_EN is defined.
// master = the counter block; slave = stream/result environment.
interface msg_len_counter_mc_if #(
  parameter int NUM_COUNT_BITS = 16,
  parameter int CH_BITS        = 2
);
  logic                      s_tvalid;
  logic                      s_tready;
  logic                      s_tlast;
  logic [CH_BITS-1:0]        s_tdest;
  logic                      len_valid;
  logic                      len_ready;
  logic [NUM_COUNT_BITS-1:0] len_data;
  logic [CH_BITS-1:0]        len_chan;
  logic                      len_split;
`ifdef MSG_LEN_COUNTER_TIMESTAMP_EN
  logic [31:0]               len_ts;

  modport master (
    input  s_tvalid, s_tready, s_tlast, s_tdest, len_ready,
    output len_valid, len_data, len_chan, len_split, len_ts
  );
  modport slave (
    output s_tvalid, s_tready, s_tlast, s_tdest, len_ready,
    input  len_valid, len_data, len_chan, len_split, len_ts
  );
`else
  modport master (
    input  s_tvalid, s_tready, s_tlast, s_tdest, len_ready,
    output len_valid, len_data, len_chan, len_split
  );
  modport slave (
    output s_tvalid, s_tready, s_tlast, s_tdest, len_ready,
    input  len_valid, len_data, len_chan, len_split
  );
`endif
endinterface

// File: rtl/msg_len_counter_mc.sv
// Multi-channel message length monitor: per-channel beat counters feeding a
// show-ahead result FIFO. Never stalls the monitored stream.
// Optional: MSG_LEN_COUNTER_TIMESTAMP_EN adds a free-running cycle counter and
// a per-record len_ts timestamp.

// One channel's beat counter; reports a close event in the cycle of the closing beat.
module msg_len_chan #(
  parameter int NB = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          beat,
  input  logic          tlast,
  input  logic          clr,
  input  logic [NB-1:0] max_len,
  output logic          push,
  output logic [NB-1:0] len,
  output logic          split,
  output logic          busy
);
  logic [NB-1:0] count_q, count_d, base, nxt;
  logic          busy_q, busy_d;

  // Clear wins over the old count, so a same-cycle beat starts a fresh message.
  always_comb begin
    base    = clr ? '0 : count_q;
    nxt     = (&base) ? base : base + NB'(1);
    push    = 1'b0;
    len     = nxt;
    split   = 1'b0;
    count_d = base;
    if (beat) begin
      // >= so a max_len lowered below the running count closes on the next beat
      if (tlast || (max_len != '0 && nxt >= max_len)) begin
        push    = 1'b1;
        split   = !tlast || (&base);
        count_d = '0;
      end else begin
        count_d = nxt;
      end
    end
    busy_d = (count_d != '0);
  end

  // Count and busy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
endmodule

module msg_len_counter_mc #(
  parameter int NUM_COUNT_BITS = 16,
  parameter int NUM_CHANNELS   = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  msg_len_counter_mc_if.master      bus,
  input  logic [NUM_CHANNELS-1:0]   clear,
  input  logic [NUM_COUNT_BITS-1:0] max_len,
  output logic [NUM_CHANNELS-1:0]   chan_busy,
  output logic [7:0]                drop_cnt
);
  localparam int CH_BITS = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int NB      = NUM_COUNT_BITS;

  typedef struct packed {
    logic [CH_BITS-1:0] chan;
    logic [NB-1:0]      len;
    logic               split;
`ifdef MSG_LEN_COUNTER_TIMESTAMP_EN
    logic [31:0]        ts;
`endif
  } rec_t;

  logic                            beat;
  logic [NUM_CHANNELS-1:0]         beat_vec, push_vec, split_vec;
  logic [NUM_CHANNELS-1:0][NB-1:0] len_vec;
  rec_t                            rec_in, head;

  assign beat = bus.s_tvalid && bus.s_tready && (32'(bus.s_tdest) < NUM_CHANNELS);

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    assign beat_vec[c] = beat && (bus.s_tdest == CH_BITS'(c));
    msg_len_chan #(.NB(NB)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .beat    (beat_vec[c]),
      .tlast   (bus.s_tlast),
      .clr     (clear[c]),
      .max_len (max_len),
      .push    (push_vec[c]),
      .len     (len_vec[c]),
      .split   (split_vec[c]),
      .busy    (chan_busy[c])
    );
  end

`ifdef MSG_LEN_COUNTER_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d;
  assign ts_d = ts_q + 32'd1;
  // Free-running cycle counter.
  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_d;
  end
`endif

  // At most one channel closes per cycle (one tdest), so select its record.
  always_comb begin
    rec_in = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (push_vec[c]) begin
        rec_in.chan  = CH_BITS'(c);
        rec_in.len   = len_vec[c];
        rec_in.split = split_vec[c];
      end
    end
`ifdef MSG_LEN_COUNTER_TIMESTAMP_EN
    rec_in.ts = ts_q;
`endif
  end

  rec_t [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W:0]        wr_q, wr_d, rd_q, rd_d;
  logic [7:0]            drop_q, drop_d;
  logic                  empty, full, push, pop, wr_en;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]) && (wr_q[PTR_W] != rd_q[PTR_W]);
  assign push  = |push_vec;
  assign pop   = !empty && bus.len_ready;
  // A same-cycle pop frees the slot, so full+pop+push still stores the record.
  assign wr_en = push && (!full || pop);

  // FIFO pointer/storage update and saturating drop counter.
  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    drop_d = drop_q;
    if (wr_en) begin
      mem_d[wr_q[PTR_W-1:0]] = rec_in;
      wr_d                   = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    if (push && !wr_en && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  // FIFO and drop counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      drop_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      drop_q <= drop_d;
    end
    mem_q <= mem_d;
  end

  assign head          = mem_q[rd_q[PTR_W-1:0]];
  assign bus.len_valid = !empty;
  assign bus.len_data  = head.len;
  assign bus.len_chan  = head.chan;
  assign bus.len_split = head.split;
`ifdef MSG_LEN_COUNTER_TIMESTAMP_EN
  assign bus.len_ts    = head.ts;
`endif
  assign drop_cnt      = drop_q;
endmodule

// File: tb/tb_msg_len_counter_mc.sv
// Scoreboard bench for msg_len_counter_mc: expected records are queued as beats
// are driven and compared as the result port hands them out.
module tb_msg_len_counter_mc;
  localparam int NB    = 16;
  localparam int NC    = 5;
  localparam int CHB   = 3;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] clear;
  logic [NB-1:0] max_len;
  logic [NC-1:0] chan_busy;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  msg_len_counter_mc_if #(.NUM_COUNT_BITS(NB), .CH_BITS(CHB)) bus ();

  msg_len_counter_mc #(.NUM_COUNT_BITS(NB), .NUM_CHANNELS(NC), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clear     (clear),
    .max_len   (max_len),
    .chan_busy (chan_busy),
    .drop_cnt  (drop_cnt)
  );

  typedef struct {
    int chan;
    int len;
    int split;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_drop = 0;
  int   cnt[NC];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Result port monitor: record accepted this cycle is checked against the queue head.
  exp_t e;
  always @(negedge clk) begin
    if (!rst && bus.len_valid && bus.len_ready) begin
      if (sb.size() == 0) chk("unexpected_rec", 1, 0);
      else begin
        e = sb.pop_front();
        chk("len_chan",  int'(bus.len_chan),  e.chan);
        chk("len_data",  int'(bus.len_data),  e.len);
        chk("len_split", int'(bus.len_split), e.split);
      end
    end
  end

  // One handshake beat; the reference count model decides whether a record is expected.
  task automatic beat(input int ch, input bit last, input logic [NC-1:0] clr);
    exp_t r;
    int   n;
    bus.s_tvalid = 1'b1;
    bus.s_tready = 1'b1;
    bus.s_tlast  = last;
    bus.s_tdest  = CHB'(ch);
    clear        = clr;
    for (int i = 0; i < NC; i++) if (clr[i]) cnt[i] = 0;
    if (ch < NC) begin
      n = cnt[ch] + 1;
      if (last || (max_len != 0 && n >= int'(max_len))) begin
        r.chan = ch; r.len = n; r.split = last ? 0 : 1;
        if (sb.size() < DEPTH || bus.len_ready) sb.push_back(r);
        else exp_drop++;
        cnt[ch] = 0;
      end else cnt[ch] = n;
    end
    @(posedge clk); #1;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    clear        = '0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      done = (sb.size() == 0) && !bus.len_valid;
    end
    chk("drain_done", int'(done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = '0; max_len = '0;
    bus.s_tvalid = 1'b0; bus.s_tready = 1'b0; bus.s_tlast = 1'b0; bus.s_tdest = '0;
    bus.len_ready = 1'b1;
    for (int i = 0; i < NC; i++) cnt[i] = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_len_valid", int'(bus.len_valid), 0);
    chk("rst_chan_busy", int'(chan_busy), 0);
    chk("rst_drop_cnt",  int'(drop_cnt), 0);
    rst = 1'b0;

    // ch1, 5 beats
    for (int i = 0; i < 5; i++) begin
      beat(1, i == 4, '0);
      if (i == 2) chk("busy1_open", int'(chan_busy[1]), 1);
    end
    drain();
    chk("busy1_closed", int'(chan_busy[1]), 0);

    // interleaved ch0/ch2, closing order ch2 then ch0
    beat(0, 0, '0); beat(2, 0, '0); beat(0, 0, '0); beat(2, 1, '0); beat(0, 1, '0);
    drain();

    // split at max_len=4 over a 10-beat message
    max_len = 16'd4;
    for (int i = 0; i < 10; i++) beat(0, i == 9, '0);
    drain();

    // max_len lowered below a running count closes on the next beat
    max_len = '0;
    for (int i = 0; i < 5; i++) beat(4, 0, '0);
    max_len = 16'd3;
    beat(4, 0, '0);
    drain();
    max_len = '0;

    // backpressure: 6 records into a 4-deep FIFO
    bus.len_ready = 1'b0;
    for (int i = 0; i < 6; i++) beat(2, 1, '0);
    chk("drop_cnt", int'(drop_cnt), exp_drop);
    chk("held_valid", int'(bus.len_valid), 1);
    bus.len_ready = 1'b1;
    drain();

    // clear with same-cycle beat, then ignored beats
    for (int i = 0; i < 7; i++) beat(3, 0, '0);
    chk("busy3_open", int'(chan_busy[3]), 1);
    beat(3, 1, 5'b01000);
    drain();
    chk("busy_after_clr", int'(chan_busy), 0);
    beat(0, 0, '0);
    beat(5, 0, '0);
    bus.s_tvalid = 1'b1; bus.s_tready = 1'b0; bus.s_tdest = 3'd0;
    @(posedge clk); #1;
    bus.s_tvalid = 1'b0;
    chk("busy_ignored", int'(chan_busy), 1);
    beat(0, 1, '0);
    drain();

    // reset mid-message with FIFO holding 2 and a nonzero drop count
    bus.len_ready = 1'b0;
    beat(1, 0, '0); beat(1, 0, '0); beat(2, 1, '0); beat(2, 1, '0);
    chk("pre_rst_valid", int'(bus.len_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_len_valid", int'(bus.len_valid), 0);
    chk("mid_rst_chan_busy", int'(chan_busy), 0);
    chk("mid_rst_drop_cnt",  int'(drop_cnt), 0);
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < NC; i++) cnt[i] = 0;
    bus.len_ready = 1'b1;
    beat(1, 0, '0); beat(1, 1, '0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
